// File: rtl/data_axi_master_pkg.sv
// Shared types and AXI constants for the MEM-stage data AXI master.
package data_axi_master_pkg;

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } mem_axi_struct;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE,
        ST_DRAIN
    } axi_state_t;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [3:0] AXI_ID_ZERO    = 4'd0;

    function automatic logic [31:0] word_align(input logic [29:0] word_addr);
        return {word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/data_axi_master_if.sv
// Single-beat AXI4 bus between the data master and memory/interconnect.
interface data_axi_master_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/data_axi_master.sv
// MEM-stage data access master: turns one pipeline load/store into a single-beat
// AXI4 read or write, holding the pipeline busy until the access completes.
module data_axi_master
    import data_axi_master_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  mem_axi_struct           req_i,
    input  logic                    excp_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic                    busy_o,
    output logic [31:0]             rdata_o,
    data_axi_master_if.master       axi
);

    axi_state_t  state_reg, state_next;
    logic [29:0] addr_reg;
    logic [3:0]  sel_reg;
    logic [31:0] data_reg;
    logic        we_reg;
    logic [31:0] rdata_reg;
    logic        ar_done_reg, ar_done_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg,  w_done_next;

    logic new_req;
    logic latch_req;
    logic capture_rdata;
    logic arvalid, rready, awvalid, wvalid, bready, busy;

    // Response codes are deliberately ignored: any response ends the access.
    assign new_req = req_i.ce && !excp_i && !flush_i;

    always_comb begin
        state_next    = state_reg;
        ar_done_next  = ar_done_reg;
        aw_done_next  = aw_done_reg;
        w_done_next   = w_done_reg;
        latch_req     = 1'b0;
        capture_rdata = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        busy          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = new_req;
                if (new_req) begin
                    latch_req    = 1'b1;
                    ar_done_next = 1'b0;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = req_i.we ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                busy    = 1'b1;
                arvalid = 1'b1;
                if (axi.arready) begin
                    ar_done_next = 1'b1;
                    state_next   = flush_i ? ST_DRAIN : ST_RD_DATA;
                end else if (flush_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_RD_DATA: begin
                busy   = 1'b1;
                rready = 1'b1;
                // A response landing with the flush completes the access; its data is dropped.
                if (axi.rvalid) begin
                    capture_rdata = !flush_i;
                    state_next    = flush_i ? ST_IDLE : ST_DONE;
                end else if (flush_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_WR_REQ: begin
                busy         = 1'b1;
                awvalid      = !aw_done_reg;
                wvalid       = !w_done_reg;
                aw_done_next = aw_done_reg || axi.awready;
                w_done_next  = w_done_reg  || axi.wready;
                if (aw_done_next && w_done_next) begin
                    state_next = flush_i ? ST_DRAIN : ST_WR_RESP;
                end else if (flush_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_WR_RESP: begin
                busy   = 1'b1;
                bready = 1'b1;
                if (axi.bvalid) begin
                    state_next = flush_i ? ST_IDLE : ST_DONE;
                end else if (flush_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (flush_i || !stall_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Finish whatever handshakes are still open, then discard the response.
                busy = 1'b1;
                if (!we_reg) begin
                    arvalid      = !ar_done_reg;
                    rready       = ar_done_reg;
                    ar_done_next = ar_done_reg || axi.arready;
                    if (ar_done_reg && axi.rvalid) begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    awvalid      = !aw_done_reg;
                    wvalid       = !w_done_reg;
                    bready       = aw_done_reg && w_done_reg;
                    aw_done_next = aw_done_reg || axi.awready;
                    w_done_next  = w_done_reg  || axi.wready;
                    if (bready && axi.bvalid) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            sel_reg     <= '0;
            data_reg    <= '0;
            we_reg      <= 1'b0;
            rdata_reg   <= '0;
            ar_done_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ar_done_reg <= ar_done_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            if (latch_req) begin
                addr_reg <= req_i.addr[31:2];
                sel_reg  <= req_i.sel;
                data_reg <= req_i.data;
                we_reg   <= req_i.we;
            end
            if (capture_rdata) begin
                rdata_reg <= axi.rdata;
            end
        end
    end

    assign busy_o  = busy && !rst;
    assign rdata_o = rdata_reg;

    assign axi.arid    = AXI_ID_ZERO;
    assign axi.araddr  = word_align(addr_reg);
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = AXI_SIZE_WORD;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arvalid;
    assign axi.rready  = rready;

    assign axi.awid    = AXI_ID_ZERO;
    assign axi.awaddr  = word_align(addr_reg);
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = AXI_SIZE_WORD;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = awvalid;

    assign axi.wdata   = data_reg;
    assign axi.wstrb   = sel_reg;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid;
    assign axi.bready  = bready;

endmodule

// File: doc/data_axi_master.md
DATA_AXI_MASTER -- requirements
Module: data_axi_master

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  core clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset (RstEnable).
REQ-004 req_i  input  mem_axi_struct  MEM-stage request: ce, we, addr[31:0], sel[3:0], data[31:0].
REQ-005 excp_i  input  1  MEM-stage instruction carries an exception; request SHALL be ignored while high.
REQ-006 stall_i  input  1  ctrl holds MEM (instruction not advancing this cycle).
REQ-007 flush_i  input  1  ctrl flushes MEM; current instruction is cancelled.
REQ-008 busy_o  output  1  to MEM axi_busy_i; high while the MEM access is incomplete.
REQ-009 rdata_o  output  32  to MEM mem_data_i; aligned read word.
REQ-010 AXI4 master ports: arvalid/arready/araddr[31:0]/arsize[2:0]; rvalid/rready/rdata[31:0]/rresp[1:0]; awvalid/awready/awaddr[31:0]/awsize[2:0]; wvalid/wready/wdata[31:0]/wstrb[3:0]/wlast; bvalid/bready/bresp[1:0]; all IDs 0, len 0, burst INCR.

Function
REQ-011 new_req = req_i.ce && !excp_i && !flush_i, evaluated only in IDLE.
REQ-012 States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE, DRAIN.
REQ-013 IDLE: new_req && !we -> RD_ADDR; new_req && we -> WR_REQ; addr/sel/data/we latched on that edge.
REQ-014 busy_o SHALL be combinational: high in IDLE when new_req, high in RD_ADDR/RD_DATA/WR_REQ/WR_RESP/DRAIN, low in DONE and idle-without-request.
REQ-015 araddr/awaddr = {latched addr[31:2],2'b00}; arsize=awsize=3'b010; wstrb = latched sel; wdata = latched data; wlast=1.
REQ-016 RD_ADDR: arvalid=1 until arready; then RD_DATA with rready=1; on rvalid capture rdata into rdata_o register, -> DONE.
REQ-017 WR_REQ: awvalid and wvalid asserted together; each deasserts independently after its handshake (aw_done/w_done flags); both done -> WR_RESP with bready=1; on bvalid -> DONE.
REQ-018 AW and W handshakes in the same cycle SHALL move directly to WR_RESP next cycle.
REQ-019 valid signals SHALL not drop before ready (AXI stability); address/data stable while valid.
REQ-020 DONE: busy_o=0, rdata_o held; stall_i=1 -> stay DONE; stall_i=0 -> IDLE (prevents re-issuing the same request).
REQ-021 flush_i in DONE -> IDLE. flush_i in RD_ADDR/RD_DATA/WR_REQ/WR_RESP -> DRAIN; outstanding handshakes complete, response discarded, rdata_o unchanged; DRAIN -> IDLE on final rvalid/bvalid (or when no response pending).
REQ-022 Non-zero rresp/bresp SHALL be treated as completion (no retry); rdata captured as-is.
REQ-023 Minimum latency: read with ready/valid immediate = 3 cycles busy (IDLE, RD_ADDR, RD_DATA), DONE on 4th.

Reset
REQ-024 On rst: state=IDLE, all valid/ready outputs 0, aw_done=w_done=0, rdata_o=0, latched request=0; rst mid-transaction abandons it with no drain.
REQ-025 busy_o SHALL be 0 in the reset cycle regardless of req_i.

Structure
REQ-026 State enum and AXI constants (size/burst/resp OKAY) SHALL live in pipeline_defines; mem_axi_struct reused unchanged.
REQ-027 Single module, no sub-module; one state register plus latch registers.

Verification
REQ-028 Load: ce=1,we=0,addr=0x1C000007; arready=1, rvalid=1 one cycle later with rdata=0xDEADBEEF -> araddr=0x1C000004, busy 3 cycles, rdata_o=0xDEADBEEF in DONE.
REQ-029 Store: we=1,addr=0x8000_0002,sel=4'b1100,data=0x12341234; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, bvalid then DONE.
REQ-030 stall_i=1 for 5 cycles in DONE with ce still high -> no second arvalid, busy_o=0 throughout.
REQ-031 flush_i in RD_DATA before rvalid -> DRAIN, busy high until rvalid, rdata_o keeps prior value, then IDLE.
REQ-032 excp_i=1 with ce=1 -> no AXI valid asserted, busy_o=0.
REQ-033 rst asserted in WR_REQ -> next cycle IDLE, awvalid=wvalid=0, busy_o=0.
